nn_param_loader: RTL and testbench

NN_PARAM_LOADER -- requirements
Module: nn_param_loader

---
 rtl/nn_pkg.sv | 17 +
 rtl/nn_param_loader.sv | 168 ++++++++++++++++
 tb/tb_nn_param_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and frame-size helper for the neural-network parameter loader.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_IN   = 3'd1,
        LOAD_BIAS = 3'd2,
        LOAD_W    = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Words per frame: n inputs, one bias, then m weight matrices of n x n.
    function automatic int frame_len(input int n, input int m);
        return n + 1 + m * n * n;
    endfunction

endpackage

// File: rtl/nn_param_loader.sv
// Streams one parameter frame (inputs, bias, weights) into output registers
// and pulses start when a well-formed frame has been fully received.
module nn_param_loader
    import nn_pkg::*;
#(
    parameter int int_part   = 3,
    parameter int fract_part = 5,
    parameter int N          = 4,
    parameter int M          = 3,
    localparam int W         = int_part + fract_part
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     load_req,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    input  logic signed [W-1:0]                      s_data,
    input  logic                                     s_last,
    output logic signed [N-1:0][W-1:0]               in_values,
    output logic signed [W-1:0]                      bias,
    output logic signed [M-1:0][N-1:0][N-1:0][W-1:0] weight,
    output logic                                     start,
    output logic                                     busy,
    output logic                                     err,
    output state_t                                   dbg_state
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = (M > 1) ? $clog2(M) : 1;

    state_t                                   r_state;
    logic                                     r_busy;
    logic                                     r_start;
    logic                                     r_err;
    logic [IW-1:0]                            r_in_idx;
    logic [IW-1:0]                            r_nrn;
    logic [LW-1:0]                            r_lay;
    logic signed [N-1:0][W-1:0]               r_in;
    logic signed [W-1:0]                      r_bias;
    logic signed [M-1:0][N-1:0][N-1:0][W-1:0] r_w;

    logic w_xfer;
    logic w_last_pos;
    logic w_early;
    logic w_write;

    // Handshake: a word moves only on a cycle where s_valid and s_ready are
    // both high; s_ready is high exactly while a LOAD state is active, and
    // the producer may insert s_valid=0 gaps at any point without effect.
    assign w_xfer     = s_valid && r_busy;
    assign w_last_pos = (r_state == LOAD_W) && (r_in_idx == IW'(N - 1))
                        && (r_nrn == IW'(N - 1)) && (r_lay == LW'(M - 1));
    assign w_early    = w_xfer && s_last && !w_last_pos;
    assign w_write    = w_xfer && !w_early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_in_idx <= '0;
            r_nrn    <= '0;
            r_lay    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_start <= 1'b0;
                    if (load_req) begin
                        r_state  <= LOAD_IN;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_in_idx <= '0;
                        r_nrn    <= '0;
                        r_lay    <= '0;
                    end
                end
                LOAD_IN: begin
                    if (w_early) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_xfer) begin
                        if (r_in_idx == IW'(N - 1)) begin
                            r_in_idx <= '0;
                            r_state  <= LOAD_BIAS;
                        end else begin
                            r_in_idx <= r_in_idx + IW'(1);
                        end
                    end
                end
                LOAD_BIAS: begin
                    if (w_early) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_xfer) begin
                        r_state <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (w_early) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_xfer) begin
                        if (w_last_pos) begin
                            r_busy <= 1'b0;
                            if (s_last) begin
                                r_state <= DONE;
                                r_start <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_err   <= 1'b1;
                            end
                        end else if (r_in_idx == IW'(N - 1)) begin
                            r_in_idx <= '0;
                            if (r_nrn == IW'(N - 1)) begin
                                r_nrn <= '0;
                                r_lay <= r_lay + LW'(1);
                            end else begin
                                r_nrn <= r_nrn + IW'(1);
                            end
                        end else begin
                            r_in_idx <= r_in_idx + IW'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_start <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    // Register file: words are stored bit-for-bit at the slot the counters
    // point to; a rejected early-last word is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in   <= '0;
            r_bias <= '0;
            r_w    <= '0;
        end else if (w_write) begin
            case (r_state)
                LOAD_IN:   r_in[r_in_idx]           <= s_data;
                LOAD_BIAS: r_bias                   <= s_data;
                LOAD_W:    r_w[r_lay][r_nrn][r_in_idx] <= s_data;
                default: ;
            endcase
        end
    end

    assign s_ready   = r_busy;
    assign busy      = r_busy;
    assign start     = r_start;
    assign err       = r_err;
    assign in_values = r_in;
    assign bias      = r_bias;
    assign weight    = r_w;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed bench for nn_param_loader: frame loads, gaps, framing errors, reset.
module tb_nn_param_loader;
    import nn_pkg::*;

    localparam int IP = 3;
    localparam int FP = 5;
    localparam int N  = 4;
    localparam int M  = 3;
    localparam int W  = IP + FP;
    localparam int T  = frame_len(N, M);

    logic                                     clk = 1'b0;
    logic                                     rst_n = 1'b0;
    logic                                     load_req = 1'b0;
    logic                                     s_valid = 1'b0;
    logic                                     s_last = 1'b0;
    logic signed [W-1:0]                      s_data = '0;
    logic                                     s_ready;
    logic                                     start;
    logic                                     busy;
    logic                                     err;
    logic signed [N-1:0][W-1:0]               in_values;
    logic signed [W-1:0]                      bias;
    logic signed [M-1:0][N-1:0][N-1:0][W-1:0] weight;
    state_t                                   dbg_state;

    int n_vec = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int ready_bad = 0;
    logic [W-1:0] exp_q[$];
    int           idx_q[$];

    nn_param_loader #(.int_part(IP), .fract_part(FP), .N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .in_values(in_values), .bias(bias), .weight(weight), .start(start),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (start) start_cnt++;
        if (s_ready && !(dbg_state inside {LOAD_IN, LOAD_BIAS, LOAD_W})) ready_bad++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] get_reg(input int k);
        int j, l, n, i;
        if (k < N) return in_values[k];
        if (k == N) return bias;
        j = k - N - 1;
        l = j / (N * N);
        n = (j / N) % N;
        i = j % N;
        return weight[l][n][i];
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_in"}, 512'(in_values), '0);
        chk({tag, "_bias"}, 512'(bias), '0);
        chk({tag, "_weight"}, 512'(weight), '0);
        chk({tag, "_start"}, 512'(start), '0);
        chk({tag, "_err"}, 512'(err), '0);
        chk({tag, "_ready"}, 512'(s_ready), '0);
        chk({tag, "_busy"}, 512'(busy), '0);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("word_ready", 512'(s_ready), 512'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // last_at: index carrying s_last (T-1 clean, -1 none, otherwise early).
    task automatic run_frame(input int base, input bit gaps, input int last_at);
        logic [W-1:0] d;
        logic         last;
        int           s0;
        bit           clean;
        clean = (last_at == T - 1);
        s0 = start_cnt;
        exp_q.delete();
        idx_q.delete();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        chk("err_clear", 512'(err), '0);
        chk("busy_on", 512'(busy), 512'(1));
        for (int k = 0; k < T; k++) begin
            d = W'(k + base);
            last = (k == last_at);
            if (gaps && (k % 2 == 1)) begin
                @(negedge clk);
                chk("gap_ready", 512'(s_ready), 512'(1));
                @(posedge clk);
                #1;
            end
            send_word(d, last);
            if (!(last && k != T - 1)) begin
                exp_q.push_back(d);
                idx_q.push_back(k);
            end
            if (k == T - 1 || last) begin
                chk("start_after_last", 512'(start), 512'(clean));
                chk("err_after_frame", 512'(err), 512'(!clean));
                chk("busy_after_frame", 512'(busy), '0);
                if (!clean) chk("state_idle", 512'(dbg_state), 512'(IDLE));
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("start_one_cycle", 512'(start), '0);
        chk("ready_off", 512'(s_ready), '0);
        chk("start_count", 512'(start_cnt - s0), 512'(clean));
        while (exp_q.size() > 0) begin
            int k;
            logic [W-1:0] e;
            e = exp_q.pop_front();
            k = idx_q.pop_front();
            chk($sformatf("sb_word%0d", k), 512'(get_reg(k)), 512'(e));
        end
    endtask

    task automatic check_counting_frame(input string tag);
        for (int i = 0; i < N; i++) chk({tag, "_in"}, 512'(in_values[i]), 512'(i));
        chk({tag, "_bias"}, 512'(bias), 512'(4));
        chk({tag, "_w000"}, 512'(weight[0][0][0]), 512'(5));
        chk({tag, "_w100"}, 512'(weight[1][0][0]), 512'(21));
        chk({tag, "_w233"}, 512'(weight[2][3][3]), 512'(52));
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        chk("rst_state", 512'(dbg_state), 512'(IDLE));
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_release");

        run_frame(0, 1'b0, T - 1);
        check_counting_frame("full");

        run_frame(0, 1'b1, T - 1);
        check_counting_frame("gapped");

        run_frame(100, 1'b0, 10);
        chk("early_word10_kept", 512'(get_reg(10)), 512'(10));
        chk("early_word9_new", 512'(get_reg(9)), 512'(109));
        chk("early_err_sticky", 512'(err), 512'(1));

        run_frame(0, 1'b0, T - 1);
        check_counting_frame("recover");

        run_frame(100, 1'b0, -1);
        chk("nolast_w233", 512'(weight[2][3][3]), 512'(152));
        chk("nolast_err", 512'(err), 512'(1));

        s0 = start_cnt;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        for (int k = 0; k <= 20; k++) send_word(W'(k + 50), 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        chk("midreset_state", 512'(dbg_state), 512'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_nostart", 512'(start_cnt - s0), '0);
        run_frame(0, 1'b0, T - 1);
        check_counting_frame("after_reset");

        chk("ready_outside_load", 512'(ready_bad), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
